fr_input_fifo: RTL
==================

FR_INPUT_FIFO -- requirements
Module: fr_input_fifo

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 16, sample width in bits.
- DEPTH, 8, storage entries; power of two, >=2.
- FRAME_LEN, 256, samples per frame; >=2.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  synchronous clear of all buffered data and the frame position.
REQ-005 start  in  1  write strobe; idata is offered this cycle.
REQ-006 idata  in  DATA_W  signed input sample.
REQ-007 in_ready  out  1  storage not full; equals !full.
REQ-008 x  out  DATA_W  signed output sample, registered.
REQ-009 done  out  1  x holds a valid sample, registered.
REQ-010 out_ready  in  1  consumer accepts x this cycle.
REQ-011 last  out  1  x is the final sample of a frame, registered.
REQ-012 full  out  1  storage level == DEPTH.
REQ-013 empty  out  1  storage level == 0; excludes the output register.
REQ-014 level  out  log2(DEPTH)+1  number of entries in storage.
REQ-015 overflow  out  1  sticky flag; a write was dropped.

Function
REQ-016 A write SHALL be accepted when start=1 and full=0; idata is stored at the write pointer, and the write pointer wraps modulo DEPTH.
REQ-017 start=1 with full=1 SHALL drop idata, leave all storage unchanged, and set overflow on the next edge.
REQ-018 An output transfer SHALL occur on an edge where done=1 and out_ready=1.
REQ-019 The output register SHALL load the storage head on an edge where storage is non-empty and either done=0 or a transfer occurs; the read pointer then advances, wrapping modulo DEPTH.
REQ-020 While done=1 and out_ready=0, x and last SHALL hold stable.
REQ-021 A transfer with empty storage SHALL clear done on that edge.
REQ-022 Minimum latency SHALL be two edges: start is accepted at edge k, and done=1 with x=idata holds after edge k+1.
REQ-023 Level SHALL update as follows:
- +1 on an accepted write with no load.
- -1 on a load with no accepted write.
- Unchanged when both occur on the same edge.
REQ-024 An accepted write into empty storage SHALL NOT bypass storage.
REQ-025 A frame counter SHALL count loads into the output register, from 0 to FRAME_LEN-1, wrapping to 0.
REQ-026 last SHALL be set with a loaded sample whose count is FRAME_LEN-1, and cleared with any other load.
REQ-027 Data order SHALL be strict FIFO, with no loss except writes dropped under REQ-017.
REQ-028 flush=1 SHALL take priority over start and out_ready and SHALL clear on that edge:
- Both pointers, level and the frame counter.
- done, last and overflow.
- The write offered in the same cycle is discarded.
REQ-029 x SHALL keep its last value after a flush or a transfer that leaves done=0.
REQ-030 Signed data SHALL pass bit-exact; the block performs no arithmetic on samples.

Reset
REQ-031 With rst=0, the block SHALL immediately drive:
- x=0, done=0, last=0, overflow=0.
- level=0, empty=1, full=0, in_ready=1.
- Pointers and frame counter = 0.
REQ-032 Storage contents SHALL need no reset.
REQ-033 Reset asserted mid-operation SHALL abandon all buffered data with no output transfer.
REQ-034 Reset deassertion SHALL be synchronised in the reset domain so that the first active edge is clean.

Verification
REQ-035 Basic latency: DATA_W=16; start=1 with idata=-1234 for 1 cycle, out_ready=1 -> done=1 and x=-1234 one edge after acceptance, for exactly one cycle, then done=0.
REQ-036 Fill and overflow: DEPTH=8, out_ready=0; write 10 samples -> 1st sample in x, level=7 after 8 writes, then 8 after the 9th write with full=1 and in_ready=0; 10th write dropped and overflow=1; drain reads 9 samples in order.
REQ-037 Simultaneous traffic: start=1 and out_ready=1 every cycle for 100 samples -> level constant after fill, in-order output, no overflow.
REQ-038 Frame boundary: FRAME_LEN=4; stream 9 samples -> last=1 on the 4th and 8th outputs only, 0 otherwise.
REQ-039 Backpressure: out_ready toggled randomly -> x and last stable whenever done=1 and out_ready=0; scoreboard matches input order.
REQ-040 Flush and reset: flush with level=5 and start=1 -> level=0, done=0, overflow=0, the same-cycle write discarded, and the frame counter restarts; rst=0 mid-stream -> all outputs at REQ-031 values immediately.

Source files
------------

// File: rtl/fr_input_fifo.sv
// -----------------------------------------------------------------------------
// fr_input_fifo
//   Sample input FIFO with a registered output stage and frame marking.
//   Samples written with `start` are buffered in a DEPTH-entry circular store,
//   then moved one at a time into an output register (x/done/last) that is
//   drained by a ready/valid style consumer handshake (done/out_ready).
//   A frame counter tags every FRAME_LEN-th sample loaded into the output
//   register with `last`.
//
// Parameters
//   DATA_W     sample width in bits
//   DEPTH      storage entries (power of two, >= 2)
//   FRAME_LEN  samples per frame (>= 2)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-low reset (deassertion synchronised here)
//   flush      synchronous clear of buffered data, frame position and flags
//   start      write strobe, idata offered this cycle
//   idata      signed input sample
//   in_ready   storage not full (== !full)
//   x          registered output sample
//   done       x holds a valid sample
//   out_ready  consumer accepts x this cycle
//   last       x is the final sample of a frame
//   full       storage level == DEPTH
//   empty      storage level == 0 (output register not counted)
//   level      entries currently in storage
//   overflow   sticky: a write was dropped because storage was full
// -----------------------------------------------------------------------------
module fr_input_fifo #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     start,
  input  logic [DATA_W-1:0]        idata,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        x,
  output logic                     done,
  input  logic                     out_ready,
  output logic                     last,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [FW-1:0] FC_MAX   = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] FC_ONE   = FW'(1);

  // ---------------------------------------------------------------------------
  // Reset synchroniser: assertion propagates immediately, release is delayed
  // by two edges so the first active edge after reset is clean.
  // ---------------------------------------------------------------------------
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wptr_q,  wptr_d;
  logic [AW-1:0]     rptr_q,  rptr_d;
  logic [AW:0]       level_q, level_d;
  logic [FW-1:0]     fcnt_q,  fcnt_d;
  logic [DATA_W-1:0] x_q,     x_d;
  logic              done_q,  done_d;
  logic              last_q,  last_d;
  logic              ovf_q,   ovf_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic xfer;
  logic load;

  assign full_w  = (level_q == LVL_FULL);
  assign empty_w = (level_q == '0);

  // flush wins over both the write and the read side.
  assign wr_acc = start && !full_w && !flush;
  assign xfer   = done_q && out_ready;
  // The output register refills when it is free or being emptied this edge.
  // Only stored entries are eligible, so a write into empty storage always
  // takes one extra edge to reach x.
  assign load   = !empty_w && (!done_q || out_ready) && !flush;

  // ---------------------------------------------------------------------------
  // Storage array: no reset needed, contents are qualified by level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wptr_q] <= idata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    x_d     = x_q;
    done_d  = done_q;
    last_d  = last_q;
    ovf_d   = ovf_q;

    if (flush) begin
      // x deliberately keeps its value; only the qualifiers are cleared.
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      fcnt_d  = '0;
      done_d  = 1'b0;
      last_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + PTR_ONE;
      end

      if (start && full_w) begin
        ovf_d = 1'b1;
      end

      if (load) begin
        rptr_d = rptr_q + PTR_ONE;
        x_d    = mem_q[rptr_q];
        done_d = 1'b1;
        last_d = (fcnt_q == FC_MAX);
        fcnt_d = (fcnt_q == FC_MAX) ? '0 : fcnt_q + FC_ONE;
      end else if (xfer) begin
        // Transfer with nothing to refill: x and last hold, done drops.
        done_d = 1'b0;
      end

      unique case ({wr_acc, load})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      fcnt_q  <= '0;
      x_q     <= '0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      fcnt_q  <= fcnt_d;
      x_q     <= x_d;
      done_q  <= done_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign full     = full_w;
  assign empty    = empty_w;
  assign in_ready = !full_w;
  assign level    = level_q;
  assign x        = x_q;
  assign done     = done_q;
  assign last     = last_q;
  assign overflow = ovf_q;

endmodule
